// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon round controller.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEED,
    REWIND,
    SHOW_ON,
    SHOW_OFF,
    ARM,
    WAIT_IN,
    ADV,
    LOSE,
    WIN
  } state_e;

  localparam logic [3:0] LED_OFF  = 4'b0000;
  localparam logic [3:0] LED_FAIL = 4'b1111;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/simon_timer.sv
// Loadable down-counter shared by the show, gap and input-timeout phases.
// Holds at zero; expired is high whenever the count is zero.
module simon_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value   = cnt_q;
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round controller: drives the sequence generator strobes, replays each
// round on the LEDs and scores the player's presses.
// state    | meaning
// IDLE     | waiting for start
// SEED     | reseed generator, level becomes 1
// REWIND   | rewind generator ahead of replay
// SHOW_ON  | current element lit
// SHOW_OFF | dark gap, generator stepped on its last cycle
// ARM      | rewind generator ahead of input
// WAIT_IN  | awaiting a press, timeout running
// ADV      | one cycle for seq to settle after a step
// LOSE     | mismatch or timeout
// WIN      | MAX_LEVEL cleared
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEVEL      = 16,
  parameter int LVL_W          = 5,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             btn_valid,
  input  logic [3:0]       btn,
  input  logic [3:0]       seq,
  output logic             randomize,
  output logic             start_over,
  output logic             next,
  output logic [3:0]       led,
  output logic [LVL_W-1:0] level,
  output logic             busy_show,
  output logic             wait_input,
  output logic             game_over,
  output logic             win
);

  localparam int TMR_W = cnt_width(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES));
  localparam logic [TMR_W-1:0] SHOW_LD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic             GAP_ONE = (GAP_CYCLES == 1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] idx_q, idx_d;
  logic [3:0]       led_q, led_d;
  logic             randomize_q, randomize_d;
  logic             start_over_q, start_over_d;
  logic             next_q, next_d;
  logic             busy_q, busy_d;
  logic             wait_q, wait_d;
  logic             over_q, over_d;
  logic             win_q, win_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expired;

  logic             more;
  logic             btn_hit;
  logic             show_next;

  simon_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  // idx is always below level while a round is active, so idx+1 cannot wrap.
  assign more    = ((idx_q + LVL_ONE) < level_q);
  assign btn_hit = is_onehot4(btn) && (btn == seq);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SEED;
      end
      SEED: begin
        level_d = LVL_ONE;
        state_d = REWIND;
      end
      REWIND: begin
        idx_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (tmr_expired) state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (tmr_expired) begin
          if (more) begin
            idx_d   = idx_q + LVL_ONE;
            state_d = SHOW_ON;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        idx_d   = '0;
        state_d = WAIT_IN;
      end
      WAIT_IN: begin
        // A press in the expiry cycle takes priority over the timeout.
        if (btn_valid) begin
          if (!btn_hit) begin
            state_d = LOSE;
          end else if (more) begin
            idx_d   = idx_q + LVL_ONE;
            state_d = ADV;
          end else if (level_q == LVL_MAX) begin
            state_d = WIN;
          end else begin
            level_d = level_q + LVL_ONE;
            state_d = REWIND;
          end
        end else if (tmr_expired) begin
          state_d = LOSE;
        end
      end
      ADV: begin
        state_d = WAIT_IN;
      end
      LOSE, WIN: begin
        if (start) state_d = SEED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q) && (state_d inside {SHOW_ON, SHOW_OFF, WAIT_IN});
    case (state_d)
      SHOW_ON:  tmr_val = SHOW_LD;
      SHOW_OFF: tmr_val = GAP_LD;
      default:  tmr_val = TOUT_LD;
    endcase
  end

  // The gap's step pulse must land in its final cycle so seq is fresh when
  // the following SHOW_ON first captures it.
  assign show_next = (state_d == SHOW_OFF) && more &&
                     ((tmr_load && GAP_ONE) || (!tmr_load && (tmr_value == TMR_W'(1))));

  always_comb begin
    randomize_d  = (state_d == SEED);
    start_over_d = (state_d == REWIND) || (state_d == ARM);
    next_d       = (state_d == ADV) || show_next;
    busy_d       = (state_d == SHOW_ON) || (state_d == SHOW_OFF);
    wait_d       = (state_d == WAIT_IN);
    over_d       = (state_d == LOSE);
    win_d        = (state_d == WIN);
    // Replay LEDs follow the state by one cycle: seq is only trusted once
    // the strobe that precedes SHOW_ON has taken effect.
    if (state_d == LOSE) begin
      led_d = LED_FAIL;
    end else if (state_d == WIN) begin
      led_d = seq;
    end else if (state_q == SHOW_ON) begin
      led_d = seq;
    end else begin
      led_d = LED_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      level_q      <= '0;
      idx_q        <= '0;
      led_q        <= LED_OFF;
      randomize_q  <= 1'b0;
      start_over_q <= 1'b0;
      next_q       <= 1'b0;
      busy_q       <= 1'b0;
      wait_q       <= 1'b0;
      over_q       <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      idx_q        <= idx_d;
      led_q        <= led_d;
      randomize_q  <= randomize_d;
      start_over_q <= start_over_d;
      next_q       <= next_d;
      busy_q       <= busy_d;
      wait_q       <= wait_d;
      over_q       <= over_d;
      win_q        <= win_d;
    end
  end

  assign randomize  = randomize_q;
  assign start_over = start_over_q;
  assign next       = next_q;
  assign led        = led_q;
  assign level      = level_q;
  assign busy_show  = busy_q;
  assign wait_input = wait_q;
  assign game_over  = over_q;
  assign win        = win_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: behavioural generator plus game-level model of
// expected LED traces, strobes and round outcomes.
module tb_simon_round_ctrl;

  localparam int S    = 4;
  localparam int G    = 2;
  localparam int T    = 20;
  localparam int MAXL = 3;
  localparam int LW   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          btn_valid = 1'b0;
  logic [3:0]    btn = 4'b0000;
  logic [3:0]    seq;
  logic          randomize, start_over, next;
  logic [3:0]    led;
  logic [LW-1:0] level;
  logic          busy_show, wait_input, game_over, win;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simon_round_ctrl #(
    .MAX_LEVEL      (MAXL),
    .LVL_W          (LW),
    .SHOW_CYCLES    (S),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .btn_valid  (btn_valid),
    .btn        (btn),
    .seq        (seq),
    .randomize  (randomize),
    .start_over (start_over),
    .next       (next),
    .led        (led),
    .level      (level),
    .busy_show  (busy_show),
    .wait_input (wait_input),
    .game_over  (game_over),
    .win        (win)
  );

  // Registered sequence generator: a strobe in cycle t shows on seq at t+1.
  logic [3:0] gen_mem [16];
  logic [3:0] gen_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) gen_mem[i] = 4'b0001;
      gen_ptr = 4'd0;
      seq <= 4'b0001;
    end else begin
      if (randomize) begin
        for (int i = 0; i < 16; i++) gen_mem[i] = 4'b0001 << $urandom_range(3, 0);
        gen_ptr = 4'd0;
      end else if (start_over) begin
        gen_ptr = 4'd0;
      end else if (next) begin
        gen_ptr = gen_ptr + 4'd1;
      end
      seq <= gen_mem[gen_ptr];
    end
  end

  // Strobes must be single-cycle and mutually exclusive.
  int strobe_err = 0;
  logic [2:0] strb_prev = 3'b000;
  always @(negedge clk) begin
    if (!rst_n) begin
      strb_prev = 3'b000;
    end else begin
      if ($countones({randomize, start_over, next}) > 1) strobe_err++;
      if ((strb_prev & {randomize, start_over, next}) != 3'b000) strobe_err++;
      strb_prev = {randomize, start_over, next};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Entered at the REWIND sample; ends at the first WAIT_IN sample.
  task automatic check_replay(input int lvl, input bit poke_start);
    int len, errs, first_bad, ph, el;
    logic [3:0] e_led;
    bit e_busy, e_next, e_so;
    len = lvl * (S + G);
    errs = 0;
    first_bad = -1;
    for (int off = 0; off <= len; off++) begin
      tick();
      ph = (off - 1) % (S + G);
      el = (off - 1) / (S + G);
      e_led  = (off >= 1 && el < lvl && ph < S) ? gen_mem[el] : 4'b0000;
      e_busy = (off < len);
      e_next = (off < len) && ((off % (S + G)) == S + G - 1) && ((off / (S + G)) < lvl - 1);
      e_so   = (off == len);
      if (led !== e_led || busy_show !== e_busy || next !== e_next ||
          start_over !== e_so || randomize !== 1'b0 || wait_input !== 1'b0) begin
        errs++;
        if (first_bad < 0) begin
          first_bad = off;
          $display("  replay L%0d off %0d: led=%b/%b busy=%b/%b next=%b/%b so=%b/%b",
                   lvl, off, led, e_led, busy_show, e_busy, next, e_next, start_over, e_so);
        end
      end
      start = poke_start && (off == 2);
    end
    start = 1'b0;
    chk($sformatf("replay trace L%0d", lvl), errs, 0);
    tick();
    chk($sformatf("wait_input after replay L%0d", lvl), int'(wait_input), 1);
    chk($sformatf("level after replay L%0d", lvl), int'(level), lvl);
  endtask

  // kind: 0 play to win, 1 wrong one-hot, 2 multi-hot 0011, 3 zero btn, 4 timeout
  task automatic play_game(input int err_lvl, input int err_idx, input int kind,
                           input int dly, input bit adv_poke, input bit show_poke);
    bit fail_here;
    int n;
    logic [3:0] b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seed randomize", int'(randomize), 1);
    tick();
    chk("rewind start_over", int'(start_over), 1);
    chk("rewind level", int'(level), 1);
    for (int lvl = 1; lvl <= MAXL; lvl++) begin
      check_replay(lvl, show_poke && lvl == 1);
      for (int i = 0; i < lvl; i++) begin
        fail_here = (kind != 0) && (lvl == err_lvl) && (i == err_idx);
        if (fail_here && kind == 4) begin
          n = 0;
          while (wait_input === 1'b1 && n < T + 5) begin
            n++;
            tick();
          end
          chk("timeout cycles", n, T);
          chk("timeout game_over", int'(game_over), 1);
          chk("timeout led", int'(led), 15);
          chk("timeout level", int'(level), lvl);
          return;
        end
        repeat (dly) tick();
        chk("wait held before press", int'(wait_input), 1);
        b = gen_mem[i];
        if (fail_here) begin
          case (kind)
            1: repeat ($urandom_range(3, 1)) b = {b[2:0], b[3]};
            2: b = 4'b0011;
            default: b = 4'b0000;
          endcase
        end
        btn = b;
        btn_valid = 1'b1;
        tick();
        btn_valid = 1'b0;
        btn = 4'b0000;
        if (fail_here) begin
          chk("lose game_over", int'(game_over), 1);
          chk("lose led", int'(led), 15);
          chk("lose level", int'(level), lvl);
          chk("lose wait_input", int'(wait_input), 0);
          return;
        end
        if (i < lvl - 1) begin
          chk("adv next", int'(next), 1);
          if (adv_poke) begin
            btn = ~gen_mem[i + 1];
            btn_valid = 1'b1;
          end
          tick();
          btn_valid = 1'b0;
          btn = 4'b0000;
          chk("adv back to wait", int'(wait_input), 1);
          chk("adv no game_over", int'(game_over), 0);
        end else if (lvl == MAXL) begin
          chk("win flag", int'(win), 1);
          chk("win level", int'(level), MAXL);
          chk("win led", int'(led), int'(gen_mem[i]));
          repeat (3) begin
            btn = 4'b0001 << $urandom_range(3, 0);
            btn_valid = 1'b1;
            tick();
          end
          btn_valid = 1'b0;
          btn = 4'b0000;
          chk("win holds after presses", int'({win, game_over, wait_input}), 4);
          chk("win level holds", int'(level), MAXL);
          return;
        end else begin
          chk("level-up start_over", int'(start_over), 1);
          chk("level-up level", int'(level), lvl + 1);
        end
      end
    end
  endtask

  typedef struct {
    int err_lvl;
    int err_idx;
    int kind;
    int dly;
    bit adv_poke;
    bit show_poke;
    int exp_lvl;
    bit exp_win;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input vec_t v, input string tag);
    play_game(v.err_lvl, v.err_idx, v.kind, v.dly, v.adv_poke, v.show_poke);
    chk({tag, " outcome win"}, int'(win), int'(v.exp_win));
    chk({tag, " outcome game_over"}, int'(game_over), int'(!v.exp_win));
    chk({tag, " outcome level"}, int'(level), v.exp_lvl);
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{0, 0, 0, 0,     1'b0, 1'b1, MAXL, 1'b1};
    tbl[1] = '{2, 1, 1, 1,     1'b0, 1'b0, 2,    1'b0};
    tbl[2] = '{1, 0, 4, 0,     1'b0, 1'b0, 1,    1'b0};
    tbl[3] = '{1, 0, 2, 3,     1'b0, 1'b0, 1,    1'b0};
    tbl[4] = '{3, 2, 3, 0,     1'b1, 1'b0, 3,    1'b0};
    tbl[5] = '{0, 0, 0, T - 1, 1'b1, 1'b0, MAXL, 1'b1};
    tbl[6] = '{3, 0, 4, 0,     1'b0, 1'b0, 3,    1'b0};
    tbl[7] = '{2, 0, 1, 5,     1'b1, 1'b0, 2,    1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({randomize, start_over, next, busy_show, wait_input, game_over, win}), 0);
    chk("reset led", int'(led), 0);
    chk("reset level", int'(level), 0);
    rst_n = 1'b1;
    tick();
    chk("release strobes", int'({randomize, start_over, next}), 0);

    for (int k = 0; k < 8; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

    for (int k = 0; k < 6; k++) begin
      rv.kind      = $urandom_range(4, 0);
      rv.err_lvl   = $urandom_range(MAXL, 1);
      rv.err_idx   = $urandom_range(rv.err_lvl - 1, 0);
      rv.dly       = $urandom_range(T - 1, 0);
      rv.adv_poke  = 1'($urandom_range(1, 0));
      rv.show_poke = 1'($urandom_range(1, 0));
      rv.exp_win   = (rv.kind == 0);
      rv.exp_lvl   = (rv.kind == 0) ? MAXL : rv.err_lvl;
      run_vec(rv, $sformatf("rnd%0d", k));
    end

    // Reset in the middle of a replay.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid-replay busy", int'(busy_show), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", int'({randomize, start_over, next, busy_show, wait_input, game_over, win}), 0);
    chk("async reset led", int'(led), 0);
    chk("async reset level", int'(level), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("release strobes again", int'({randomize, start_over, next}), 0);
    chk("idle after reset", int'({busy_show, wait_input, game_over, win}), 0);
    run_vec(tbl[1], "post-reset");

    chk("strobe protocol", strobe_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
